// File: rtl/school_seat_pkg.sv
// Shared types and sizing for the study-room seat reservation table.
package school_seat_pkg;

    localparam int unsigned NUM_SEATS  = 32;
    localparam int unsigned AWAY_LIMIT = 30;
    localparam int unsigned TIME_MOD   = 1440;

    typedef enum logic [1:0] {
        StFree     = 2'd0,
        StAway     = 2'd1,
        StOccupied = 2'd2
    } seat_state_e;

    typedef enum logic [1:0] {
        ReqRelease = 2'd0,
        ReqAway    = 2'd1,
        ReqOccupy  = 2'd2
    } req_e;

    typedef enum logic [1:0] {
        ErrNone           = 2'd0,
        ErrSeatTaken      = 2'd1,
        ErrStudentHasSeat = 2'd2,
        ErrBadRequest     = 2'd3
    } err_code_e;

endpackage

// File: rtl/seat_entry.sv
// One seat of the table: state/owner/stamp registers plus AWAY-timeout aging.
module seat_entry
    import school_seat_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cur_time,
    input  logic        time_ok,
    input  logic        wr_en,
    input  seat_state_e wr_state,
    input  logic [31:0] wr_owner,
    output seat_state_e state,
    output logic [31:0] owner,
    output logic        busy_next
);

    seat_state_e state_q, state_d;
    logic [31:0] owner_q, owner_d;
    logic [10:0] stamp_q, stamp_d;
    logic [11:0] elapsed;
    logic        expire;

    // Modular elapsed minutes so an AWAY that spans midnight ages correctly.
    always_comb begin
        if (cur_time >= stamp_q) begin
            elapsed = {1'b0, cur_time} - {1'b0, stamp_q};
        end else begin
            elapsed = {1'b0, cur_time} + 12'(TIME_MOD) - {1'b0, stamp_q};
        end
        expire = (state_q == StAway) && time_ok && (elapsed > 12'(AWAY_LIMIT));
    end

    // An accepted write takes priority over aging on the same edge.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        stamp_d = stamp_q;
        if (wr_en) begin
            state_d = wr_state;
            owner_d = (wr_state == StFree) ? 32'd0 : wr_owner;
            stamp_d = cur_time;
        end else if (expire) begin
            state_d = StFree;
            owner_d = 32'd0;
        end
        busy_next = (state_d != StFree);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFree;
            owner_q <= 32'd0;
            stamp_q <= 11'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            stamp_q <= stamp_d;
        end
    end

    assign state = state_q;
    assign owner = owner_q;

endmodule

// File: rtl/school_seating_system.sv
// Seat reservation table top: request arbitration, owner search, status read and counter.
module school_seating_system
    import school_seat_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Student_No,
    input  logic [4:0]  Seat_No,
    input  logic        write,
    input  logic [10:0] Time,
    input  logic [1:0]  Seat_State,
    input  logic [4:0]  rd_seat,
    output logic [1:0]  rd_state,
    output logic [31:0] rd_student,
    output logic        ack,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [5:0]  occupied_cnt
);

    seat_state_e           seat_state [NUM_SEATS];
    logic [31:0]           seat_owner [NUM_SEATS];
    logic [NUM_SEATS-1:0]  busy_next;
    logic [NUM_SEATS-1:0]  wr_sel;

    logic        time_ok;
    logic        has_seat;
    logic        accept;
    err_code_e   code;
    seat_state_e new_state;
    logic [5:0]  cnt_d;

    logic        ack_q, err_q;
    err_code_e   err_code_q;
    logic [5:0]  cnt_q;

    assign time_ok = (Time < 11'(TIME_MOD));

    // Any-seat owner match; free seats always hold owner 0.
    always_comb begin
        has_seat = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (seat_state[i] != StFree && seat_owner[i] == Student_No) has_seat = 1'b1;
        end
    end

    always_comb begin
        accept    = 1'b0;
        code      = ErrNone;
        new_state = StFree;
        case (Seat_State)
            ReqAway:   new_state = StAway;
            ReqOccupy: new_state = StOccupied;
            default:   new_state = StFree;
        endcase
        if (Seat_State == 2'd3 || Student_No == 32'd0 || !time_ok) begin
            code = ErrBadRequest;
        end else if (seat_state[Seat_No] == StFree) begin
            if (Seat_State != ReqOccupy) code = ErrBadRequest;
            else if (has_seat)           code = ErrStudentHasSeat;
            else                         accept = 1'b1;
        end else if (seat_owner[Seat_No] == Student_No) begin
            accept = 1'b1;
        end else begin
            code = ErrSeatTaken;
        end
    end

    for (genvar i = 0; i < NUM_SEATS; i++) begin : g_seat
        assign wr_sel[i] = write && accept && (Seat_No == 5'(i));

        seat_entry u_seat (
            .clk       (clk),
            .rst       (rst),
            .cur_time  (Time),
            .time_ok   (time_ok),
            .wr_en     (wr_sel[i]),
            .wr_state  (new_state),
            .wr_owner  (Student_No),
            .state     (seat_state[i]),
            .owner     (seat_owner[i]),
            .busy_next (busy_next[i])
        );
    end

    always_comb begin
        cnt_d = 6'd0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            cnt_d = cnt_d + 6'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            cnt_q      <= 6'd0;
        end else begin
            ack_q <= write && accept;
            err_q <= write && !accept;
            if (write) err_code_q <= accept ? ErrNone : code;
            cnt_q <= cnt_d;
        end
    end

    assign ack          = ack_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign occupied_cnt = cnt_q;
    assign rd_state     = seat_state[rd_seat];
    assign rd_student   = seat_owner[rd_seat];

endmodule

// File: tb/tb_school_seating_system.sv
// Scoreboard bench for school_seating_system: expected ack/err/code queued per request.
module tb_school_seating_system;

    typedef struct {
        logic       ack;
        logic       err;
        logic [1:0] code;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] Student_No;
    logic [4:0]  Seat_No;
    logic        write;
    logic [10:0] Time;
    logic [1:0]  Seat_State;
    logic [4:0]  rd_seat;
    logic [1:0]  rd_state;
    logic [31:0] rd_student;
    logic        ack;
    logic        err;
    logic [1:0]  err_code;
    logic [5:0]  occupied_cnt;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e_mon;
    logic was_wr;

    school_seating_system dut (
        .clk          (clk),
        .rst          (rst),
        .Student_No   (Student_No),
        .Seat_No      (Seat_No),
        .write        (write),
        .Time         (Time),
        .Seat_State   (Seat_State),
        .rd_seat      (rd_seat),
        .rd_state     (rd_state),
        .rd_student   (rd_student),
        .ack          (ack),
        .err          (err),
        .err_code     (err_code),
        .occupied_cnt (occupied_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request; the expected response is queued and checked by the monitor.
    task automatic req(input logic [31:0] id, input logic [4:0] seat, input logic [1:0] st,
                       input logic [10:0] t, input logic exp_ack, input logic [1:0] exp_code);
        exp_t e;
        @(negedge clk);
        Student_No = id;
        Seat_No    = seat;
        Seat_State = st;
        Time       = t;
        write      = 1'b1;
        e.ack  = exp_ack;
        e.err  = !exp_ack;
        e.code = exp_ack ? 2'd0 : exp_code;
        sb.push_back(e);
        @(posedge clk);
        #2;
        write = 1'b0;
    endtask

    task automatic idle(input logic [10:0] t);
        @(negedge clk);
        write = 1'b0;
        Time  = t;
        @(posedge clk);
        #2;
    endtask

    task automatic seat_is(input string tag, input logic [4:0] seat, input logic [1:0] st,
                           input logic [31:0] id);
        rd_seat = seat;
        #1;
        check({tag, "_state"}, 32'(rd_state), 32'(st));
        check({tag, "_owner"}, rd_student, id);
    endtask

    // Response monitor: pops one expectation per write edge, otherwise expects no pulse.
    always begin
        @(posedge clk);
        was_wr = write && !rst;
        #1;
        if (was_wr) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("resp_ack", 32'(ack), 32'(e_mon.ack));
                check("resp_err", 32'(err), 32'(e_mon.err));
                check("resp_code", 32'(err_code), 32'(e_mon.code));
            end
        end else if (!rst) begin
            check("idle_ack", 32'(ack), 32'd0);
            check("idle_err", 32'(err), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; write = 1'b0; Student_No = '0; Seat_No = '0;
        Seat_State = '0; Time = '0; rd_seat = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_cnt", 32'(occupied_cnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        seat_is("rst_s0", 5'd0, 2'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        req(32'd201819186, 5'd1, 2'd2, 11'd0, 1'b1, 2'd0);
        seat_is("occ_s1", 5'd1, 2'd2, 32'd201819186);
        check("cnt_1", 32'(occupied_cnt), 32'd1);

        req(32'd201912352, 5'd2, 2'd2, 11'd0, 1'b1, 2'd0);
        req(32'd201912352, 5'd2, 2'd1, 11'd1430, 1'b1, 2'd0);
        seat_is("away_s2", 5'd2, 2'd1, 32'd201912352);
        check("cnt_2", 32'(occupied_cnt), 32'd2);

        req(32'd2019123179, 5'd1, 2'd2, 11'd1430, 1'b0, 2'd1);
        seat_is("taken_s1", 5'd1, 2'd2, 32'd201819186);
        idle(11'd1430);
        check("code_held", 32'(err_code), 32'd1);

        req(32'd201819186, 5'd5, 2'd2, 11'd1430, 1'b0, 2'd2);
        seat_is("has_s5", 5'd5, 2'd0, 32'd0);

        // 20 minutes past midnight is exactly 30 minutes after 1430: still held.
        idle(11'd20);
        seat_is("age30_s2", 5'd2, 2'd1, 32'd201912352);
        check("cnt_age30", 32'(occupied_cnt), 32'd2);
        idle(11'd21);
        seat_is("age31_s2", 5'd2, 2'd0, 32'd0);
        check("cnt_age31", 32'(occupied_cnt), 32'd1);

        req(32'd5, 5'd3, 2'd3, 11'd21, 1'b0, 2'd3);
        req(32'd0, 5'd3, 2'd2, 11'd21, 1'b0, 2'd3);
        req(32'd7, 5'd3, 2'd1, 11'd21, 1'b0, 2'd3);
        req(32'd7, 5'd3, 2'd0, 11'd21, 1'b0, 2'd3);
        req(32'd9, 5'd3, 2'd2, 11'd1500, 1'b0, 2'd3);
        seat_is("bad_s3", 5'd3, 2'd0, 32'd0);

        req(32'd201819186, 5'd1, 2'd0, 11'd21, 1'b1, 2'd0);
        seat_is("rel_s1", 5'd1, 2'd0, 32'd0);
        check("cnt_rel", 32'(occupied_cnt), 32'd0);
        req(32'd201819186, 5'd5, 2'd2, 11'd22, 1'b1, 2'd0);
        seat_is("move_s5", 5'd5, 2'd2, 32'd201819186);

        req(32'd300, 5'd7, 2'd2, 11'd100, 1'b1, 2'd0);
        req(32'd300, 5'd7, 2'd1, 11'd100, 1'b1, 2'd0);
        check("cnt_s7", 32'(occupied_cnt), 32'd2);
        // Would expire at 200, but the owner's renewal on the same edge wins.
        req(32'd300, 5'd7, 2'd1, 11'd200, 1'b1, 2'd0);
        seat_is("renew_s7", 5'd7, 2'd1, 32'd300);
        idle(11'd230);
        seat_is("renew30_s7", 5'd7, 2'd1, 32'd300);
        idle(11'd231);
        seat_is("renew31_s7", 5'd7, 2'd0, 32'd0);
        check("cnt_renew", 32'(occupied_cnt), 32'd1);

        // Reset with a concurrent write: the write must be dropped.
        @(negedge clk);
        rst = 1'b1; write = 1'b1; Student_No = 32'd999; Seat_No = 5'd9;
        Seat_State = 2'd2; Time = 11'd300;
        @(posedge clk);
        #2;
        write = 1'b0;
        check("midrst_cnt", 32'(occupied_cnt), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        seat_is("midrst_s9", 5'd9, 2'd0, 32'd0);
        seat_is("midrst_s5", 5'd5, 2'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        req(32'd201819186, 5'd9, 2'd2, 11'd301, 1'b1, 2'd0);
        check("post_rst_cnt", 32'(occupied_cnt), 32'd1);
        idle(11'd302);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
